// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states,
// datapath select codes, ALU commands and condition codes.
package ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned COND_W   = 4;
    localparam int unsigned OP_W     = 2;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned REG_W    = 4;
    localparam int unsigned FLAGS_W  = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // ResultSrc encodings
    localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
    localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
    localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

    // ALUSrcB encodings
    localparam logic [SEL_W-1:0] SRCB_RD2  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_EXT  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

    // ALUControl encodings
    localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
    localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
    localparam logic [SEL_W-1:0] ALU_AND = 2'b10;
    localparam logic [SEL_W-1:0] ALU_ORR = 2'b11;

    // Instruction class (Op field)
    localparam logic [OP_W-1:0] OP_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_BR  = 2'b10;

    // Data-processing cmd field (Funct[4:1])
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [COND_W-1:0] COND_EQ = 4'b0000;
    localparam logic [COND_W-1:0] COND_NE = 4'b0001;
    localparam logic [COND_W-1:0] COND_CS = 4'b0010;
    localparam logic [COND_W-1:0] COND_CC = 4'b0011;
    localparam logic [COND_W-1:0] COND_MI = 4'b0100;
    localparam logic [COND_W-1:0] COND_PL = 4'b0101;
    localparam logic [COND_W-1:0] COND_VS = 4'b0110;
    localparam logic [COND_W-1:0] COND_VC = 4'b0111;
    localparam logic [COND_W-1:0] COND_HI = 4'b1000;
    localparam logic [COND_W-1:0] COND_LS = 4'b1001;
    localparam logic [COND_W-1:0] COND_GE = 4'b1010;
    localparam logic [COND_W-1:0] COND_LT = 4'b1011;
    localparam logic [COND_W-1:0] COND_GT = 4'b1100;
    localparam logic [COND_W-1:0] COND_LE = 4'b1101;
    localparam logic [COND_W-1:0] COND_AL = 4'b1110;
    localparam logic [COND_W-1:0] COND_NV = 4'b1111;

endpackage

// File: rtl/cond_unit.sv
// Combinational ARM condition check: Cond field against NZCV flags.
module cond_unit
    import ctrl_pkg::*;
(
    input  logic [COND_W-1:0]  cond,
    input  logic [FLAGS_W-1:0] flags,
    output logic               cond_ex
);

    logic n, z, c, v;

    // Evaluate all condition codes from the registered flags
    always_comb begin
        {n, z, c, v} = flags;
        cond_ex      = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = ~(n ^ v);
            COND_LT: cond_ex = n ^ v;
            COND_GT: cond_ex = ~z & ~(n ^ v);
            COND_LE: cond_ex = z | (n ^ v);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b0;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: instruction sequencing FSM, datapath
// selects, write enables, NZCV flag register and conditional execution.
// Optional: define CTRL_NOWRITE_EN to decode cmd 1010 as CMP.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [COND_W-1:0]   Cond,
    input  logic [OP_W-1:0]     Op,
    input  logic [FUNCT_W-1:0]  Funct,
    input  logic [REG_W-1:0]    Rd,
    input  logic [FLAGS_W-1:0]  ALUFlags,
    output logic                PCWrite,
    output logic                MemWrite,
    output logic                RegWrite,
    output logic                IRWrite,
    output logic                AdrSrc,
    output logic [SEL_W-1:0]    ResultSrc,
    output logic                ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    ImmSrc,
    output logic [SEL_W-1:0]    RegSrc,
    output logic [SEL_W-1:0]    ALUControl
);

    state_t             state, state_next;
    logic [FLAGS_W-1:0] flags;
    logic               cond_ex, cond_ex_q;

    logic               is_fetch, ir_w, alu_op, reg_w, mem_w, branch;
    logic [1:0]         flag_w;
    logic [SEL_W-1:0]   alu_ctl_dec;
    logic [1:0]         flag_w_dec;
    logic               dp_writes;

    cond_unit u_cond (
        .cond    (Cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RESET_STATE;
        else          state <= state_next;
    end

    // Next-state sequencing
    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (Op)
                    OP_MEM:  state_next = MEMADR;
                    OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    OP_BR:   state_next = BRANCH;
                    default: state_next = FETCH;
                endcase
            end
            MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:    state_next = MEMWB;
            EXECUTER: state_next = ALUWB;
            EXECUTEI: state_next = ALUWB;
            MEMWB, MEMWR, ALUWB, BRANCH: state_next = FETCH;
            default:  state_next = FETCH;
        endcase
    end

    // Data-processing cmd decode; unimplemented cmds become flagless ADD
    always_comb begin
        alu_ctl_dec = ALU_ADD;
        flag_w_dec  = 2'b00;
        dp_writes   = 1'b0;
        case (Funct[4:1])
            CMD_ADD: begin alu_ctl_dec = ALU_ADD; flag_w_dec = {Funct[0], Funct[0]}; dp_writes = 1'b1; end
            CMD_SUB: begin alu_ctl_dec = ALU_SUB; flag_w_dec = {Funct[0], Funct[0]}; dp_writes = 1'b1; end
            CMD_AND: begin alu_ctl_dec = ALU_AND; flag_w_dec = {Funct[0], 1'b0};     dp_writes = 1'b1; end
            CMD_ORR: begin alu_ctl_dec = ALU_ORR; flag_w_dec = {Funct[0], 1'b0};     dp_writes = 1'b1; end
            CMD_CMP: begin
`ifdef CTRL_NOWRITE_EN
                alu_ctl_dec = ALU_SUB;
                flag_w_dec  = {Funct[0], Funct[0]};
`else
                alu_ctl_dec = ALU_ADD;
                flag_w_dec  = 2'b00;
`endif
                dp_writes   = 1'b0;
            end
            default: ;
        endcase
    end

    // Per-state controls, instruction decode and condition-gated strobes
    always_comb begin
        is_fetch  = 1'b0;
        ir_w      = 1'b0;
        alu_op    = 1'b0;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        case (state)
            FETCH: begin
                is_fetch  = 1'b1;
                ir_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:   ALUSrcB = SRCB_EXT;
            MEMRD:    AdrSrc  = 1'b1;
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
            end
            EXECUTER: begin
                ALUSrcB = SRCB_RD2;
                alu_op  = 1'b1;
            end
            EXECUTEI: begin
                ALUSrcB = SRCB_EXT;
                alu_op  = 1'b1;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = dp_writes;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_EXT;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase

        ALUControl = alu_op ? alu_ctl_dec : ALU_ADD;
        flag_w     = alu_op ? flag_w_dec  : 2'b00;
        ImmSrc     = Op;
        RegSrc     = {Op == OP_MEM, Op == OP_BR};

        // Strobes are forced low while reset_n is asserted
        RegWrite = reset_n & reg_w & cond_ex_q;
        MemWrite = reset_n & mem_w & cond_ex_q;
        IRWrite  = reset_n & ir_w;
        PCWrite  = reset_n & (is_fetch | (cond_ex_q & (branch | (reg_w & (Rd == 4'hF)))));
    end

    // Condition result latched at the end of DECODE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)             cond_ex_q <= 1'b0;
        else if (state == DECODE) cond_ex_q <= cond_ex;
    end

    // NZCV register, written only by executing instructions that pass
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= '0;
        end else if (alu_op && cond_ex_q) begin
            if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
            if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: reset checks, a table of
// directed instructions, an async reset during a store, and random
// instructions against an instruction-level reference model.
module tb_multicycle_controller;
    import ctrl_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       memw;
        logic       regw;
        logic       irw;
        logic       adr;
        logic [1:0] res;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] imm;
        logic [1:0] regsrc;
        logic [1:0] aluc;
    } ctl_t;

    typedef struct {
        state_t st;
        ctl_t   c;
    } step_t;

    typedef struct {
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        logic [3:0] alu;
        logic [3:0] flags_exp;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] m_flags;
    vec_t       tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ctl_t dut_ctl();
        ctl_t a;
        a = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, RegSrc, ALUControl};
        return a;
    endfunction

    // ARM condition rule: pairs of codes share a base test, odd code inverts
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic ctl_t base_ctl(input logic [1:0] op);
        ctl_t c;
        c        = '0;
        c.imm    = op;
        c.regsrc = {op == 2'b01, op == 2'b10};
        return c;
    endfunction

    function automatic step_t mk(input state_t st, input ctl_t c);
        step_t s;
        s.st = st;
        s.c  = c;
        return s;
    endfunction

    // Build the expected cycle-by-cycle behaviour of one instruction, then apply it
    task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd,
                             input logic [3:0] alu);
        step_t      q[$];
        ctl_t       c;
        bit         pass, writes, s;
        logic [1:0] aluc, fw;

        pass   = cond_pass(cond, m_flags);
        s      = funct[0];
        writes = 1'b1;
        case (funct[4:1])
            4'd4:  begin aluc = 2'd0; fw = {s, s};    end
            4'd2:  begin aluc = 2'd1; fw = {s, s};    end
            4'd0:  begin aluc = 2'd2; fw = {s, 1'b0}; end
            4'd12: begin aluc = 2'd3; fw = {s, 1'b0}; end
`ifdef CTRL_NOWRITE_EN
            4'd10: begin aluc = 2'd1; fw = {s, s}; writes = 1'b0; end
`endif
            default: begin aluc = 2'd0; fw = 2'b00; writes = 1'b0; end
        endcase

        c = base_ctl(op); c.srca = 1; c.srcb = 2; c.res = 2; c.irw = 1; c.pcw = 1;
        q.push_back(mk(FETCH, c));
        c = base_ctl(op); c.srca = 1; c.srcb = 2; c.res = 2;
        q.push_back(mk(DECODE, c));
        case (op)
            2'b01: begin
                c = base_ctl(op); c.srcb = 1;
                q.push_back(mk(MEMADR, c));
                if (funct[0]) begin
                    c = base_ctl(op); c.adr = 1;
                    q.push_back(mk(MEMRD, c));
                    c = base_ctl(op); c.res = 1; c.regw = pass; c.pcw = pass && (rd == 4'hF);
                    q.push_back(mk(MEMWB, c));
                end else begin
                    c = base_ctl(op); c.adr = 1; c.memw = pass;
                    q.push_back(mk(MEMWR, c));
                end
            end
            2'b00: begin
                c = base_ctl(op); c.srcb = funct[5] ? 2'd1 : 2'd0; c.aluc = aluc;
                q.push_back(mk(funct[5] ? EXECUTEI : EXECUTER, c));
                c = base_ctl(op); c.res = 0; c.regw = pass && writes;
                c.pcw = pass && writes && (rd == 4'hF);
                q.push_back(mk(ALUWB, c));
                if (pass) begin
                    if (fw[1]) m_flags[3:2] = alu[3:2];
                    if (fw[0]) m_flags[1:0] = alu[1:0];
                end
            end
            2'b10: begin
                c = base_ctl(op); c.srcb = 1; c.res = 2; c.pcw = pass;
                q.push_back(mk(BRANCH, c));
            end
            default: ;
        endcase

        Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = alu;
        foreach (q[i]) begin
            @(negedge clk);
            chk("state", 32'(dut.state), 32'(q[i].st));
            chk($sformatf("ctl_%s", q[i].st.name()), 32'(dut_ctl()), 32'(q[i].c));
            @(posedge clk);
            #1;
        end
        chk("back_to_fetch", 32'(dut.state), 32'(FETCH));
        chk("model_flags", 32'(dut.flags), 32'(m_flags));
    endtask

    initial begin
        // {cond, op, funct, rd, ALUFlags, flags after}
        tbl[0]  = '{4'hE, 2'b00, 6'b101001, 4'h1, 4'b1001, 4'b1001}; // ADDS imm
        tbl[1]  = '{4'hE, 2'b01, 6'b011001, 4'h2, 4'b0000, 4'b1001}; // LDR
        tbl[2]  = '{4'hE, 2'b01, 6'b011000, 4'h3, 4'b0000, 4'b1001}; // STR
        tbl[3]  = '{4'hE, 2'b00, 6'b000101, 4'h4, 4'b0110, 4'b0110}; // SUBS
        tbl[4]  = '{4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 4'b0110}; // BEQ taken
        tbl[5]  = '{4'hE, 2'b00, 6'b000001, 4'h5, 4'b0000, 4'b0010}; // ANDS: only NZ
        tbl[6]  = '{4'hE, 2'b00, 6'b000101, 4'h6, 4'b0000, 4'b0000}; // SUBS -> 0000
        tbl[7]  = '{4'h0, 2'b10, 6'b100000, 4'h0, 4'b0000, 4'b0000}; // BEQ not taken
        tbl[8]  = '{4'hE, 2'b00, 6'b001000, 4'hF, 4'b1111, 4'b0000}; // ADD to PC
        tbl[9]  = '{4'hE, 2'b11, 6'b000000, 4'h0, 4'b1111, 4'b0000}; // Op=11
        tbl[10] = '{4'h0, 2'b00, 6'b101001, 4'h1, 4'b1111, 4'b0000}; // EQ fails
`ifdef CTRL_NOWRITE_EN
        tbl[11] = '{4'hE, 2'b00, 6'b010101, 4'h7, 4'b0100, 4'b0100}; // CMP
`else
        tbl[11] = '{4'hE, 2'b00, 6'b010101, 4'h7, 4'b0100, 4'b0000}; // unimplemented
`endif
        tbl[12] = '{4'hE, 2'b00, 6'b011001, 4'h8, 4'b1000, 4'b1000}; // ORRS

        reset_n = 1'b0;
        Cond = 4'h0; Op = 2'b00; Funct = 6'b101001; Rd = 4'h0; ALUFlags = 4'h0;
        m_flags = 4'h0;

        // Reset held: strobes low, state FETCH, flags clear
        @(negedge clk);
        chk("rst_state", 32'(dut.state), 32'(FETCH));
        chk("rst_irwrite", 32'(IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(PCWrite), 32'd0);
        chk("rst_regwrite", 32'(RegWrite), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_flags", 32'(dut.flags), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].cond, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].alu);
            chk($sformatf("tbl%0d_flags", i), 32'(dut.flags), 32'(tbl[i].flags_exp));
        end

        // Async reset in the middle of a store
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011000; Rd = 4'h3; ALUFlags = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("memwr_state", 32'(dut.state), 32'(MEMWR));
        chk("memwr_memwrite", 32'(MemWrite), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_memwrite", 32'(MemWrite), 32'd0);
        chk("midrst_state", 32'(dut.state), 32'(FETCH));
        chk("midrst_pcwrite", 32'(PCWrite), 32'd0);
        chk("midrst_irwrite", 32'(IRWrite), 32'd0);
        chk("midrst_flags", 32'(dut.flags), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_flags = 4'h0;

        // Random instruction stream against the reference model
        for (int k = 0; k < 200; k++) begin
            run_instr(4'($urandom_range(15)), 2'($urandom_range(3)), 6'($urandom_range(63)),
                      4'($urandom_range(15)), 4'($urandom_range(15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM datapath (shared instruction/data memory, single ALU reused for PC+4).
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB states, drives datapath selects and write enables, and holds NZCV flags.
- Includes conditional-execution logic.
- Sits beside the datapath; inputs come from the instruction register and ALU.

Parameters:
- RESET_STATE, FETCH, state entered on reset (kept for bring-up only; default used in production).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- Cond  input  4  Instr[31:28]
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20]
- Rd  input  4  Instr[15:12]
- ALUFlags  input  4  NZCV from ALU, current cycle
- PCWrite  output  1  PC register enable
- MemWrite  output  1  memory write enable
- RegWrite  output  1  register file write enable
- IRWrite  output  1  instruction register enable
- AdrSrc  output  1  0 = PC, 1 = ALUOut drives memory address
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  output  1  0 = RD1, 1 = PC
- ALUSrcB  output  2  00 RD2, 01 ExtImm, 10 constant 4
- ImmSrc  output  2  extend select
- RegSrc  output  2  register address select
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR

Behaviour:
- Async reset (reset_n low):
  - state = FETCH; Flags = 0000; cond_ex_q = 0.
  - All enables deasserted immediately, except IRWrite and PCWrite, which follow FETCH decode once reset_n is high.
- States and next-state transitions; every transition takes one clk:
  - FETCH -> DECODE.
  - DECODE:
    - Op=01 -> MEMADR.
    - Op=00 with Funct[5]=1 -> EXECUTEI.
    - Op=00 with Funct[5]=0 -> EXECUTER.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH, with no writes.
  - MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTER / EXECUTEI -> ALUWB.
  - MEMWB / MEMWR / ALUWB / BRANCH -> FETCH.
- Per-state controls; unlisted outputs are 0:
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD, MEMWR: AdrSrc=1. MEMWR also asserts MemW.
  - MEMWB: ResultSrc=01, RegW.
  - EXECUTER: ALUSrcB=00, ALUOp. EXECUTEI: ALUSrcB=01, ALUOp.
  - ALUWB: ResultSrc=00, RegW.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch.
- Instruction-level decode (all states):
  - ImmSrc=Op; RegSrc[0]=(Op==10); RegSrc[1]=(Op==01).
- ALUControl:
  - When ALUOp: Funct[4:1] 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Other cmd -> ADD, FlagW=00, RegW suppressed.
  - Otherwise ADD.
- FlagW (when ALUOp): FlagW[1]=Funct[0]; FlagW[0]=Funct[0]&(ADD|SUB).
- Conditional execution:
  - CondEx is evaluated in DECODE from Cond and the registered Flags, then latched into cond_ex_q at the end of DECODE.
  - Evaluation covers all 15 ARM conds; 1110 = always, 1111 = never.
- Gated outputs:
  - RegWrite = RegW & cond_ex_q.
  - MemWrite = MemW & cond_ex_q.
  - PCWrite = FETCH | (cond_ex_q & (Branch | (RegW & Rd==1111))).
- Flags update:
  - Updated only in EXECUTER/EXECUTEI, when cond_ex_q=1.
  - Flags[3:2] <= ALUFlags[3:2] if FlagW[1]; Flags[1:0] <= ALUFlags[1:0] if FlagW[0].
- Latency: branch 3 clk; DP 4 clk; STR 4 clk; LDR 5 clk.
- Reset mid-instruction: returns to FETCH asynchronously; partial writes are abandoned, and no write strobe may glitch high.

Optional Feature:
- Macro CTRL_NOWRITE_EN.
- Defined:
  - cmd 1010 (CMP) decodes as SUB with RegW suppressed in ALUWB.
  - FlagW follows the S bit as for SUB.
- Undefined: 1010 is handled as an unimplemented cmd (ADD, no flags, no write).

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum.
  - ResultSrc / ALUSrcB / ALUControl localparam encodings.
  - Cond code constants.
- Sub-module cond_unit: combinational Cond+Flags -> CondEx.
- The flags register and cond_ex_q stay in the top.

Test Plan:
- Reset with reset_n=0, then release:
  - State is FETCH: IRWrite=1, PCWrite=1, Flags=0000.
  - With Op=00, Funct=101001 (ADDS imm), next is DECODE, then EXECUTEI.
- LDR (Op=01, Funct[0]=1, Cond=1110):
  - State sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - RegWrite=1 only in MEMWB with ResultSrc=01.
  - STR (Funct[0]=0): MemWrite=1 only in MEMWR.
- SUBS:
  - Funct=000101 with ALUFlags=0110 drives Flags=0110 after EXECUTER.
  - A following BEQ (Cond=0000, Op=10) asserts PCWrite in BRANCH.
  - The same BEQ with Flags=0000 leaves PCWrite=0 in BRANCH.
- ADD with Rd=1111, Cond=1110: PCWrite=1 and RegWrite=1 in ALUWB.
- Op=11: DECODE returns directly to FETCH; RegWrite, MemWrite and PCWrite stay 0 throughout.
- Assert reset_n=0 asynchronously during MEMWR: MemWrite drops within the same cycle and the state returns to FETCH.
